// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage
//
// Owns the program counter and drives the synchronous read port of the
// instruction memory (1-cycle read latency). Each returned word is paired with
// the PC it was fetched from and presented to decode as {valid, pc, instr}.
// Decode back-pressure (stall_i) freezes the stage. A redirect from EX
// (redirect_i) is issued to memory in the same cycle, which discards the
// wrong-path fetch and produces a single bubble.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   When defined, redirect targets are word-aligned before being issued. The
//   presented PC keeps the original unaligned target and if_misalign_o flags it.
//   When undefined, targets are issued unmodified and if_misalign_o does not exist.
//
// Ports
//   clk_i          in   clock, all state updates on posedge
//   rst_i          in   synchronous reset, active-high
//   stall_i        in   decode cannot accept if_* this cycle
//   redirect_i     in   taken branch/jump; flush and refetch
//   redirect_pc_i  in   redirect target (byte address)
//   imem_rden_o    out  read enable to instruction memory
//   imem_addr_o    out  byte address to instruction memory
//   imem_data_i    in   word returned one cycle after rden (held while rden=0)
//   if_valid_o     out  if_pc_o/if_instr_o hold a live instruction
//   if_pc_o        out  PC of the presented instruction
//   if_instr_o     out  presented instruction (NOP_INSTR when not valid)
//   if_misalign_o  out  presented PC was not 4-byte aligned (feature build only)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_rden_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        if_misalign_o
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_next;
  logic [31:0] pc_q, pc_next;
  logic        rsp_valid_q, rsp_valid_next;
  logic [31:0] rsp_pc_q, rsp_pc_next;

  // Address actually sent to memory for a redirect target.
  logic [31:0] redirect_addr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        rsp_mis_q, rsp_mis_next;
  assign redirect_addr = {redirect_pc_i[31:2], 2'b00};
`else
  assign redirect_addr = redirect_pc_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      rsp_mis_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_next;
      pc_q        <= pc_next;
      rsp_valid_q <= rsp_valid_next;
      rsp_pc_q    <= rsp_pc_next;
`ifdef FETCH_MISALIGN_CHK_EN
      rsp_mis_q   <= rsp_mis_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_q;
    pc_next        = pc_q;
    rsp_valid_next = rsp_valid_q;
    rsp_pc_next    = rsp_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    rsp_mis_next   = rsp_mis_q;
`endif
    imem_rden_o    = 1'b0;
    imem_addr_o    = pc_q;

    unique case (state_q)
      // First cycle out of reset: nothing is presented yet, so there is no
      // stall or redirect to honour; simply issue the reset PC.
      S_IDLE: begin
        imem_rden_o    = 1'b1;
        imem_addr_o    = pc_q;
        pc_next        = pc_q + 32'd4;
        rsp_valid_next = 1'b1;
        rsp_pc_next    = pc_q;
        state_next     = S_RUN;
      end
      S_RUN: begin
        if (redirect_i) begin
          // Redirect beats stall: the presented instruction is dropped, so
          // decode not accepting it is irrelevant.
          imem_rden_o    = 1'b1;
          imem_addr_o    = redirect_addr;
          pc_next        = redirect_addr + 32'd4;
          rsp_valid_next = 1'b1;
          rsp_pc_next    = redirect_pc_i;
`ifdef FETCH_MISALIGN_CHK_EN
          rsp_mis_next   = |redirect_pc_i[1:0];
`endif
        end else if (stall_i) begin
          // No read: memory keeps its output, so the presented word is stable.
          imem_rden_o = 1'b0;
        end else begin
          imem_rden_o    = 1'b1;
          imem_addr_o    = pc_q;
          pc_next        = pc_q + 32'd4;
          rsp_valid_next = 1'b1;
          rsp_pc_next    = pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
          rsp_mis_next   = 1'b0;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A read issued during reset would be discarded anyway.
    if (rst_i) begin
      imem_rden_o = 1'b0;
    end
  end

  // Outputs are forced to their idle values while reset is held so that a
  // mid-stream reset hides the in-flight instruction immediately.
  assign if_valid_o = rsp_valid_q & ~rst_i;
  assign if_pc_o    = rst_i ? RESET_PC : rsp_pc_q;
  assign if_instr_o = (rsp_valid_q && !rst_i) ? imem_data_i : NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
  assign if_misalign_o = rsp_valid_q & rsp_mis_q & ~rst_i;
`endif

endmodule
